// File: rtl/router_port_reader.sv
// -----------------------------------------------------------------------------
// router_port_reader
//
// Reader end of one router output port. It pops bytes from the port FIFO using
// the vld_out / read_enb / soft_reset handshake. It parses each packet into a
// header, a payload and a parity byte. The header and payload bytes are passed
// on to a valid/ready sink through a 2-entry skid buffer. The parity byte is
// consumed here and never forwarded.
//
// Parameters
//   PORT_ID  address this port serves; compared against header[1:0]
//   CNT_W    width of pkt_count
//
// Ports
//   clk, resetn   rising-edge clock, asynchronous active-low reset
//   vld_out       port FIFO non-empty
//   soft_reset    synchronizer flush of this port's FIFO
//   data_out      FIFO read data, valid the cycle after read_enb is sampled
//   read_enb      FIFO pop request (combinational)
//   m_data        forwarded byte, taken from the skid head
//   m_valid       m_data is valid
//   m_sop, m_eop  first / last forwarded byte of a packet
//   m_ready       sink accepts the byte when m_valid & m_ready
//   parity_err    1-cycle pulse: parity byte != XOR(header, payload)
//   addr_err      1-cycle pulse: header[1:0] != PORT_ID
//   abort         1-cycle pulse: soft_reset hit while a packet was in progress
//   pkt_count     count of completed packets; wraps at 2^CNT_W
// -----------------------------------------------------------------------------
module router_port_reader #(
    parameter logic [1:0] PORT_ID = 2'd0,
    parameter int         CNT_W   = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             vld_out,
    input  logic             soft_reset,
    input  logic [7:0]       data_out,
    output logic             read_enb,
    output logic [7:0]       m_data,
    output logic             m_valid,
    output logic             m_sop,
    output logic             m_eop,
    input  logic             m_ready,
    output logic             parity_err,
    output logic             addr_err,
    output logic             abort,
    output logic [CNT_W-1:0] pkt_count
);

    typedef struct packed {
        logic       sop;
        logic       eop;
        logic [7:0] data;
    } beat_t;

    typedef enum logic [1:0] {
        ST_HDR = 2'd0,
        ST_PLD = 2'd1,
        ST_PAR = 2'd2
    } state_t;

    state_t      state;
    logic [5:0]  len;
    logic [5:0]  cnt;
    logic [7:0]  par;
    logic        infl;      // a read was issued last cycle; data_out carries its byte

    beat_t [1:0] skid;
    logic        rd_ptr;
    logic        wr_ptr;
    logic [1:0]  occ;

    logic        pop;
    logic        push;
    beat_t       wbeat;
    logic [2:0]  occ_proj;

    assign m_valid = (occ != 2'd0);
    assign pop     = m_valid & m_ready;

    // Occupancy the skid will have after this edge, counting the byte that is
    // returning right now. A read issued now only lands next cycle, so issuing
    // it while this projection is below 2 can never overflow the skid. The
    // parity byte is counted too even though it is never stored. This is a
    // conservative choice that keeps the check independent of the parser.
    assign occ_proj = {1'b0, occ} - {2'b00, pop} + {2'b00, infl};
    assign read_enb = vld_out & ~soft_reset & (occ_proj < 3'd2);

    // Only header and payload bytes are stored. The byte that returns during
    // a soft_reset cycle is dropped.
    assign push = infl & ~soft_reset & (state != ST_PAR);

    always_comb begin
        wbeat      = '0;
        wbeat.data = data_out;
        wbeat.sop  = (state == ST_HDR);
        if (state == ST_HDR)
            wbeat.eop = (data_out[7:2] == 6'd0);
        else
            wbeat.eop = (cnt == len - 6'd1);
    end

    assign m_data = skid[rd_ptr].data;
    assign m_sop  = m_valid & skid[rd_ptr].sop;
    assign m_eop  = m_valid & skid[rd_ptr].eop;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= ST_HDR;
            len        <= 6'd0;
            cnt        <= 6'd0;
            par        <= 8'd0;
            infl       <= 1'b0;
            skid       <= '0;
            rd_ptr     <= 1'b0;
            wr_ptr     <= 1'b0;
            occ        <= 2'd0;
            parity_err <= 1'b0;
            addr_err   <= 1'b0;
            abort      <= 1'b0;
            pkt_count  <= '0;
        end else begin
            parity_err <= 1'b0;
            addr_err   <= 1'b0;
            abort      <= 1'b0;
            infl       <= read_enb;   // read_enb is already 0 while soft_reset is high

            if (soft_reset) begin
                // Drop everything downstream of the FIFO. Report an abort only
                // if some of a packet had already been taken in.
                occ    <= 2'd0;
                rd_ptr <= 1'b0;
                wr_ptr <= 1'b0;
                state  <= ST_HDR;
                cnt    <= 6'd0;
                abort  <= (state != ST_HDR) || (occ != 2'd0);
            end else begin
                // A write and a pop in the same cycle are safe even when the
                // skid is full. The write goes into the slot that the pop frees.
                if (push) begin
                    skid[wr_ptr] <= wbeat;
                    wr_ptr       <= ~wr_ptr;
                end
                if (pop)
                    rd_ptr <= ~rd_ptr;
                occ <= occ + {1'b0, push} - {1'b0, pop};

                if (infl) begin
                    unique case (state)
                        ST_HDR: begin
                            len      <= data_out[7:2];
                            par      <= data_out;
                            cnt      <= 6'd0;
                            addr_err <= (data_out[1:0] != PORT_ID);
                            state    <= (data_out[7:2] != 6'd0) ? ST_PLD : ST_PAR;
                        end
                        ST_PLD: begin
                            par <= par ^ data_out;
                            cnt <= cnt + 6'd1;
                            if (cnt == len - 6'd1)
                                state <= ST_PAR;
                        end
                        ST_PAR: begin
                            parity_err <= (data_out != par);
                            pkt_count  <= pkt_count + CNT_W'(1);
                            state      <= ST_HDR;
                        end
                        default: state <= ST_HDR;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_router_port_reader.sv
// -----------------------------------------------------------------------------
// tb_router_port_reader
//
// Bench for router_port_reader. The port FIFO is modelled as a queue of bytes,
// each tagged with its role in its packet. Expected sink beats and error flags
// are built one packet at a time when the packet is queued. Inputs are driven
// on the falling edge and outputs are sampled 1 ns later.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_router_port_reader;

    localparam logic [1:0] PID = 2'd1;
    localparam int         CW  = 4;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          vld_out = 1'b0;
    logic          soft_reset = 1'b0;
    logic          m_ready = 1'b0;
    logic [7:0]    data_out = 8'd0;
    logic          read_enb, m_valid, m_sop, m_eop;
    logic          parity_err, addr_err, abort;
    logic [7:0]    m_data;
    logic [CW-1:0] pkt_count;

    router_port_reader #(.PORT_ID(PID), .CNT_W(CW)) dut (
        .clk(clk), .resetn(resetn), .vld_out(vld_out), .soft_reset(soft_reset),
        .data_out(data_out), .read_enb(read_enb), .m_data(m_data),
        .m_valid(m_valid), .m_sop(m_sop), .m_eop(m_eop), .m_ready(m_ready),
        .parity_err(parity_err), .addr_err(addr_err), .abort(abort),
        .pkt_count(pkt_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        bit         hdr;
        bit         par;
        bit         pe;
        bit         ae;
    } fbyte_t;

    fbyte_t        fifo_q[$];
    fbyte_t        nxt;
    bit            has_next = 0;
    logic [9:0]    exp_out[$];      // {sop, eop, data}
    logic [7:0]    pl[64];

    int            n_chk = 0, n_err = 0;
    bit            exp_pe = 0, exp_ae = 0, exp_ab = 0, started = 0, prev_stall = 0;
    logic [9:0]    prev_beat = '0;
    logic [CW-1:0] exp_cnt = '0;
    int            wr_cnt = 0, acc_cnt = 0, cyc = 0;
    int            first_ret = -1, first_vld = -1, last_acc = -1;
    int            pe_seen = 0, ae_seen = 0, ab_seen = 0, rd_seen = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Queue one packet: the header, then hdr[7:2] bytes from pl[], then parity.
    task automatic push_pkt(input logic [7:0] hdr, input bit bad, input logic [7:0] bad_val);
        fbyte_t     b;
        logic [7:0] p;
        int         len;
        len = int'(hdr[7:2]);
        p   = hdr;
        b.data = hdr; b.hdr = 1; b.par = 0; b.pe = 0; b.ae = (hdr[1:0] != PID);
        fifo_q.push_back(b);
        exp_out.push_back({1'b1, (len == 0), hdr});
        for (int i = 0; i < len; i++) begin
            p = p ^ pl[i];
            b.data = pl[i]; b.hdr = 0; b.par = 0; b.pe = 0; b.ae = 0;
            fifo_q.push_back(b);
            exp_out.push_back({1'b0, (i == len - 1), pl[i]});
        end
        b.data = bad ? bad_val : p; b.hdr = 0; b.par = 1; b.ae = 0;
        b.pe   = (b.data != p);
        fifo_q.push_back(b);
    endtask

    task automatic cycle(input bit rdy, input bit srst);
        logic [9:0] beat;
        @(negedge clk);
        cyc++;
        data_out   = has_next ? nxt.data : 8'($urandom);
        if (has_next && first_ret < 0) first_ret = cyc;
        m_ready    = rdy;
        soft_reset = srst;
        if (srst) fifo_q.delete();
        vld_out = (fifo_q.size() != 0);
        #1;
        beat = {m_sop, m_eop, m_data};
        chk("parity_err", parity_err, exp_pe);
        chk("addr_err", addr_err, exp_ae);
        chk("abort", abort, exp_ab);
        chk("pkt_count", pkt_count, exp_cnt);
        chk("rd_when_empty", read_enb & ~vld_out, 0);
        if (srst) chk("rd_in_srst", read_enb, 0);
        if (prev_stall) begin
            chk("hold_valid", m_valid, 1);
            chk("hold_beat", beat, prev_beat);
        end
        if (parity_err) pe_seen++;
        if (addr_err) ae_seen++;
        if (abort) ab_seen++;
        if (read_enb) rd_seen++;
        if (m_valid && first_vld < 0) first_vld = cyc;

        // Work out what this edge should produce, seen from the next cycle.
        exp_pe = 0; exp_ae = 0; exp_ab = 0;
        if (srst) exp_ab = started || (wr_cnt != acc_cnt);
        if (m_valid && m_ready) begin
            if (exp_out.size() == 0) chk("extra_beat", m_valid, 0);
            else chk("beat", beat, exp_out.pop_front());
            acc_cnt++;
            last_acc = cyc;
        end
        if (srst) begin
            exp_out.delete();
            started = 0; wr_cnt = 0; acc_cnt = 0; has_next = 0;
        end else begin
            if (has_next) begin
                if (nxt.par) begin
                    exp_pe  = nxt.pe;
                    exp_cnt = exp_cnt + 1'b1;
                    started = 0;
                end else begin
                    wr_cnt++;
                    if (nxt.hdr) begin
                        started = 1;
                        exp_ae  = nxt.ae;
                    end
                end
            end
            has_next = 0;
            if (read_enb) begin
                if (fifo_q.size() == 0) chk("rd_fifo_empty", read_enb, 0);
                else begin
                    nxt = fifo_q.pop_front();
                    has_next = 1;
                end
            end
        end
        prev_stall = m_valid && !m_ready && !srst;
        prev_beat  = beat;
    endtask

    task automatic drain(input int budget, input bit rnd);
        int n;
        n = 0;
        while ((fifo_q.size() != 0 || has_next || exp_out.size() != 0 || started) && n < budget) begin
            cycle(rnd ? ($urandom_range(0, 3) != 0) : 1'b1, 1'b0);
            n++;
        end
        chk("drain_timeout", (n < budget), 1);
        cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn = 0; vld_out = 0; soft_reset = 0; m_ready = 0;
        fifo_q.delete(); exp_out.delete();
        has_next = 0; started = 0; wr_cnt = 0; acc_cnt = 0; exp_cnt = '0;
        exp_pe = 0; exp_ae = 0; exp_ab = 0; prev_stall = 0;
        #1;
        chk("rst_read_enb", read_enb, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_sop_eop", {m_sop, m_eop}, 0);
        chk("rst_pulses", {parity_err, addr_err, abort}, 0);
        chk("rst_pkt_count", pkt_count, 0);
        repeat (2) @(negedge clk);
        resetn = 1;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, n;
        logic [7:0] hdr;
        do_reset();

        // 1: good packet of length 3 at 1 byte/cycle
        pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33;
        first_ret = -1; first_vld = -1; pe_seen = 0; ae_seen = 0;
        push_pkt(8'h0D, 0, 8'h00);
        drain(100, 0);
        chk("t1_vld_after_return", first_vld - first_ret, 1);
        chk("t1_throughput", last_acc - first_vld, 3);
        chk("t1_count", pkt_count, 1);
        chk("t1_no_err", pe_seen + ae_seen, 0);

        // 2: same packet with a bad parity byte
        pe_seen = 0;
        push_pkt(8'h0D, 1, 8'h00);
        drain(100, 0);
        chk("t2_pe_pulses", pe_seen, 1);
        chk("t2_count", pkt_count, 2);

        // 3: zero-length packet
        push_pkt(8'h01, 0, 8'h00);
        drain(100, 0);
        chk("t3_count", pkt_count, 3);

        // 4: sink stalls for 10 cycles in the middle of the payload
        for (int i = 0; i < 20; i++) pl[i] = 8'($urandom);
        push_pkt(8'h51, 0, 8'h00);
        base = acc_cnt; n = 0;
        while (acc_cnt - base < 3 && n < 50) begin cycle(1'b1, 1'b0); n++; end
        chk("t4_start_timeout", (n < 50), 1);
        rd_seen = 0;
        repeat (10) cycle(1'b0, 1'b0);
        chk("t4_stall_reads_le2", (rd_seen <= 2), 1);
        drain(200, 0);
        chk("t4_count", pkt_count, 4);

        // 5: soft_reset after 2 payload bytes, then a fresh packet
        for (int i = 0; i < 5; i++) pl[i] = 8'($urandom);
        push_pkt(8'h15, 0, 8'h00);
        base = acc_cnt; n = 0;
        while (acc_cnt - base < 3 && n < 50) begin cycle(1'b1, 1'b0); n++; end
        chk("t5_start_timeout", (n < 50), 1);
        ab_seen = 0;
        cycle(1'b1, 1'b1);
        cycle(1'b1, 1'b0);
        chk("t5_abort_pulse", ab_seen, 1);
        chk("t5_m_valid_cleared", m_valid, 0);
        pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33;
        push_pkt(8'h0D, 0, 8'h00);
        drain(100, 0);
        chk("t5_count", pkt_count, 5);

        // 6: wrong address, still forwarded and counted
        ae_seen = 0;
        push_pkt(8'h0E, 0, 8'h00);
        drain(100, 0);
        chk("t6_ae_pulses", ae_seen, 1);
        chk("t6_count", pkt_count, 6);

        // Hard reset in the middle of a packet: no abort, count cleared
        for (int i = 0; i < 10; i++) pl[i] = 8'($urandom);
        push_pkt(8'h29, 0, 8'h00);
        repeat (4) cycle(1'b1, 1'b0);
        ab_seen = 0;
        do_reset();
        cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b0);
        chk("rst_mid_no_abort", ab_seen, 0);

        // Random traffic: mixed lengths, addresses, bad parity, backpressure, flushes
        n = 0;
        for (int c = 0; c < 6000; c++) begin
            if (fifo_q.size() < 6 && n < 150 && $urandom_range(0, 3) != 0) begin
                hdr = {6'($urandom_range(0, 15)), 2'($urandom)};
                if ($urandom_range(0, 9) == 0) hdr[7:2] = 6'd63;
                for (int i = 0; i < 64; i++) pl[i] = 8'($urandom);
                push_pkt(hdr, ($urandom_range(0, 4) == 0), 8'($urandom));
                n++;
            end
            cycle(($urandom_range(0, 3) != 0), ($urandom_range(0, 199) == 0));
        end
        drain(3000, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
